instr_fetch_sequencer: RTL and testbench
========================================

// Module: instr_fetch_sequencer
// PURPOSE
//  Upstream stage of the processor controller. Owns the instruction register (IR) and the
//  2-bit timestep counter that the controller decodes. It fetches instruction words from the
//  external data port with a valid/ready handshake, stalls the timestep while external data
//  is required but absent, and honours the controller's IRin/Ext/Clr strobes.
//  It also counts retired instructions and flags a sequencing error.
// PARAMETERS
//  IW      10  instruction/data word width
//  TSW     2   timestep counter width (timesteps 0..2**TSW-1)
//  CNT_W   16  retired-instruction counter width
// PORTS
//  clk            in   1      system clock, rising edge
//  rst_n          in   1      asynchronous active-low reset
//  run            in   1      1 = execute instructions; 0 = halt at next instruction boundary
//  data           in   IW     external data word (instruction or LOAD operand)
//  data_valid     in   1      data holds a valid word this cycle
//  data_ready     out  IW->1  sequencer consumes data this cycle (handshake completes on valid&ready)
//  IRin           in   1      from controller: latch data into IR
//  Ext            in   1      from controller: external data needed on the bus this timestep
//  Clr            in   1      from controller: instruction complete, return timestep to 0
//  IR             out  IW     instruction register, to controller
//  timestep       out  TSW    current timestep, to controller
//  stall          out  1      timestep frozen waiting for data_valid
//  instr_done     out  1      one-cycle pulse, cycle after an instruction retires
//  instr_count    out  CNT_W  retired-instruction count, wraps modulo 2**CNT_W
//  seq_err        out  1      sticky: last timestep reached without Clr
// BEHAVIOUR
//  Reset (async, rst_n=0): IR=0, timestep=0, instr_count=0, instr_done=0, seq_err=0, state=S_IDLE.
//  States: S_IDLE, S_RUN (registered).
//   S_IDLE: timestep held 0, data_ready=0, stall=0, IR held. run=1 -> S_RUN next cycle.
//   S_RUN : stall = Ext & ~data_valid (combinational). data_ready = Ext & data_valid.
//           advance = ~stall. All updates below happen only on advance.
//  On advance in S_RUN:
//   - IRin=1 -> IR <= data (same edge as handshake).
//   - timestep==0: Clr ignored (controller decodes stale IR at ts0); timestep <= 1.
//   - timestep!=0 & Clr=1: timestep <= 0; instr_done <= 1; instr_count <= instr_count+1;
//     if run=0 -> S_IDLE, else stay S_RUN.
//   - timestep==max & Clr=0: timestep <= 0, seq_err <= 1, no count, no instr_done.
//   - otherwise timestep <= timestep+1.
//  On stall: IR, timestep, instr_count unchanged; instr_done <= 0.
//  instr_done is 0 in every cycle not immediately following a retire.
//  run falling mid-instruction: instruction completes; S_IDLE entered only on the Clr edge.
//  run falling at timestep 0 while stalled: stays S_RUN until fetch completes.
//  Fetch latency: with data_valid held 1, IR valid 1 cycle after ts0; min instruction 2 cycles.
//  Reset mid-operation: all state discarded immediately; no partial IR load.
//  seq_err cleared only by reset.
// STRUCTURE
//  Package blueberry_pkg: seq_state_t enum {S_IDLE,S_RUN}; localparams IW, TSW, TS_FETCH='0,
//   TS_LAST='1; shared with processorController for IR/timestep widths.
//  Sub-module timestep_counter (clk, rst_n, en, clr, ts, at_last): en/clr counter with wrap flag.
//  Top holds FSM, IR register, handshake logic, retire counter, seq_err.
// TESTING
//  1 Reset: rst_n=0 mid-run at ts=2 -> IR=0, timestep=0, instr_count=0, state S_IDLE same cycle.
//  2 COPY fetch: run=1, data=10'b01_10_0001_00 valid, IRin/Ext at ts0 then Clr at ts1
//    -> IR=0x184 after ts0, timestep 0,1,0, instr_done pulse, instr_count=1.
//  3 Stall: LOAD at ts1 with Ext=1, data_valid=0 for 3 cycles -> timestep stays 1, stall=1,
//    data_ready=0; data_valid=1 -> timestep 0 next edge, count+1.
//  4 Halt: run=0 at ts2 of ALU op -> completes ts3 with Clr, enters S_IDLE, timestep held 0.
//  5 Missing Clr: drive IRin at ts0 then no Clr for ts1..3 -> timestep wraps to 0, seq_err=1,
//    instr_count unchanged.
//  6 Clr at ts0 with IRin=1 -> IR loads data, timestep advances to 1, no count.

Source files
------------

// File: rtl/instr_fetch_sequencer_pkg.sv
// Shared definitions for the instruction fetch sequencer and the processor
// controller that decodes its IR and timestep outputs.
//   IW       instruction/data word width
//   TSW      timestep counter width
//   CNT_W    retired-instruction counter width
//   TS_FETCH timestep at which the next instruction word is fetched
//   TS_LAST  final timestep; reaching it without Clr is a sequencing error
package instr_fetch_sequencer_pkg;

  localparam int IW    = 10;
  localparam int TSW   = 2;
  localparam int CNT_W = 16;

  localparam logic [TSW-1:0] TS_FETCH = '0;
  localparam logic [TSW-1:0] TS_LAST  = '1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } seq_state_t;

endpackage

// File: rtl/instr_fetch_sequencer_if.sv
// External data port of the fetch sequencer: a word source offering data with
// a valid strobe, and the sequencer accepting it with ready.
//   data        word offered by the source (instruction or LOAD operand)
//   data_valid  source holds a valid word this cycle
//   data_ready  sequencer consumes the word this cycle (transfer on valid & ready)
// master = data source, slave = sequencer.
interface instr_fetch_sequencer_if
  import instr_fetch_sequencer_pkg::*;
#(
  parameter int IW = instr_fetch_sequencer_pkg::IW
);

  logic [IW-1:0] data;
  logic          data_valid;
  logic          data_ready;

  modport master (
    output data,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data,
    input  data_valid,
    output data_ready
  );

endinterface

// File: rtl/instr_fetch_sequencer_timestep_counter.sv
// Timestep counter for the fetch sequencer.
//   clk, rst_n  clock and asynchronous active-low reset
//   en          advance this cycle (frozen when low)
//   clr         with en: return to timestep 0 instead of incrementing
//   ts          current timestep
//   at_last     ts is at its final value
module timestep_counter #(
  parameter int TSW = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           clr,
  output logic [TSW-1:0] ts,
  output logic           at_last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts <= '0;
    end else if (en) begin
      if (clr) ts <= '0;
      else     ts <= ts + 1'b1;
    end
  end

  assign at_last = &ts;

endmodule

// File: rtl/instr_fetch_sequencer.sv
// Instruction fetch sequencer: upstream stage of the processor controller.
// Owns the instruction register and timestep counter, fetches words over a
// valid/ready port, freezes the timestep while the controller needs external
// data that is not yet valid, counts retired instructions and flags
// instructions that run off the last timestep without Clr.
//   clk, rst_n   clock and asynchronous active-low reset
//   run          1 = execute; 0 = halt at the next instruction boundary
//   bus          data / data_valid / data_ready word port (slave side)
//   IRin         latch the data word into IR
//   Ext          external data needed this timestep
//   Clr          instruction complete, return timestep to 0
//   IR           instruction register
//   timestep     current timestep
//   stall        timestep frozen waiting for data_valid
//   instr_done   one-cycle pulse in the cycle after a retire
//   instr_count  retired-instruction count (wraps)
//   seq_err      sticky: last timestep reached without Clr
module instr_fetch_sequencer
  import instr_fetch_sequencer_pkg::*;
#(
  parameter int IW    = instr_fetch_sequencer_pkg::IW,
  parameter int TSW   = instr_fetch_sequencer_pkg::TSW,
  parameter int CNT_W = instr_fetch_sequencer_pkg::CNT_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    run,
  instr_fetch_sequencer_if.slave  bus,
  input  logic                    IRin,
  input  logic                    Ext,
  input  logic                    Clr,
  output logic [IW-1:0]           IR,
  output logic [TSW-1:0]          timestep,
  output logic                    stall,
  output logic                    instr_done,
  output logic [CNT_W-1:0]        instr_count,
  output logic                    seq_err
);

  seq_state_t state;
  logic       in_run;
  logic       adv;
  logic       ts_zero;
  logic       at_last;
  logic       retire;
  logic       wrap_err;

  assign in_run         = (state == S_RUN);
  assign stall          = in_run & Ext & ~bus.data_valid;
  assign bus.data_ready = in_run & Ext & bus.data_valid;
  assign adv            = in_run & ~stall;
  assign ts_zero        = (timestep == '0);

  // Clr is ignored at timestep 0: the controller is still decoding the
  // previous IR there, so a Clr seen then belongs to the old instruction.
  assign retire   = adv & ~ts_zero & Clr;
  // at_last implies a nonzero timestep, so this never overlaps the ts0 case.
  assign wrap_err = adv & at_last & ~Clr;

  timestep_counter #(
    .TSW (TSW)
  ) u_ts (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (adv),
    .clr     (retire | wrap_err),
    .ts      (timestep),
    .at_last (at_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      IR          <= '0;
      instr_done  <= 1'b0;
      instr_count <= '0;
      seq_err     <= 1'b0;
    end else begin
      instr_done <= retire;
      if (adv && IRin) IR <= bus.data;
      if (retire)      instr_count <= instr_count + 1'b1;
      if (wrap_err)    seq_err <= 1'b1;
      case (state)
        S_IDLE:  if (run) state <= S_RUN;
        // Halting is only allowed on a retire edge, so a dropped run lets
        // the current instruction (including a pending fetch) finish first.
        S_RUN:   if (retire && !run) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
module tb_instr_fetch_sequencer;

  localparam logic [9:0] D1 = 10'b01_10_0001_00;  // 0x184, COPY
  localparam logic [9:0] D2 = 10'h2AA;
  localparam logic [9:0] D3 = 10'h155;
  localparam logic [9:0] D4 = 10'h3C0;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        IRin;
  logic        Ext;
  logic        Clr;
  logic [9:0]  IR;
  logic [1:0]  timestep;
  logic        stall;
  logic        instr_done;
  logic [15:0] instr_count;
  logic        seq_err;

  int n_cmp  = 0;
  int n_fail = 0;

  instr_fetch_sequencer_if #(.IW(10)) bus ();

  instr_fetch_sequencer #(
    .IW    (10),
    .TSW   (2),
    .CNT_W (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .bus         (bus),
    .IRin        (IRin),
    .Ext         (Ext),
    .Clr         (Clr),
    .IR          (IR),
    .timestep    (timestep),
    .stall       (stall),
    .instr_done  (instr_done),
    .instr_count (instr_count),
    .seq_err     (seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        run;
    logic [9:0]  data;
    logic        valid;
    logic        irin;
    logic        ext;
    logic        clr;
    logic [9:0]  ir;
    logic [1:0]  ts;
    logic        stall;
    logic        ready;
    logic        done;
    logic [15:0] cnt;
    logic        err;
  } vec_t;

  vec_t tbl [24];

  function automatic vec_t mk(input logic r, input logic [9:0] d, input logic v,
                              input logic ii, input logic e, input logic c,
                              input logic [9:0] ir, input logic [1:0] ts,
                              input logic st, input logic rd, input logic dn,
                              input logic [15:0] cnt, input logic err);
    vec_t x;
    x.run = r; x.data = d; x.valid = v; x.irin = ii; x.ext = e; x.clr = c;
    x.ir = ir; x.ts = ts; x.stall = st; x.ready = rd; x.done = dn;
    x.cnt = cnt; x.err = err;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic drive(input logic r, input logic [9:0] d, input logic v,
                       input logic ii, input logic e, input logic c);
    run = r; bus.data = d; bus.data_valid = v; IRin = ii; Ext = e; Clr = c;
  endtask

  initial begin
    // Row inputs are applied just after a rising edge; expected outputs are
    // the registered state produced by the previous edge plus the
    // combinational response to the row's own inputs.
    //            run data valid IRin Ext Clr |  IR  ts st rd dn cnt err
    tbl[0]  = mk(0, D1, 1, 0, 1, 0,   10'h0, 0, 0, 0, 0, 0, 0); // idle: no ready
    tbl[1]  = mk(1, D2, 0, 1, 0, 0,   10'h0, 0, 0, 0, 0, 0, 0); // IRin ignored in idle
    tbl[2]  = mk(1, D1, 1, 1, 1, 0,   10'h0, 0, 0, 1, 0, 0, 0); // COPY fetch at ts0
    tbl[3]  = mk(1, 10'h0, 0, 0, 0, 1, D1, 1, 0, 0, 0, 0, 0);   // Clr at ts1
    tbl[4]  = mk(1, D2, 1, 1, 1, 1,   D1,    0, 0, 1, 1, 1, 0); // Clr at ts0 ignored
    tbl[5]  = mk(1, D3, 0, 1, 1, 1,   D2,    1, 1, 0, 0, 1, 0); // LOAD stall
    tbl[6]  = mk(1, D3, 0, 1, 1, 1,   D2,    1, 1, 0, 0, 1, 0);
    tbl[7]  = mk(1, D3, 0, 1, 1, 1,   D2,    1, 1, 0, 0, 1, 0);
    tbl[8]  = mk(1, D3, 1, 0, 1, 1,   D2,    1, 0, 1, 0, 1, 0); // operand arrives
    tbl[9]  = mk(1, D4, 1, 1, 1, 0,   D2,    0, 0, 1, 1, 2, 0); // ALU fetch
    tbl[10] = mk(1, 10'h0, 0, 0, 0, 0, D4,   1, 0, 0, 0, 2, 0);
    tbl[11] = mk(0, 10'h0, 0, 0, 0, 0, D4,   2, 0, 0, 0, 2, 0); // run drops at ts2
    tbl[12] = mk(0, 10'h0, 0, 0, 0, 1, D4,   3, 0, 0, 0, 2, 0); // Clr at ts3 -> idle
    tbl[13] = mk(0, D1, 1, 1, 1, 0,   D4,    0, 0, 0, 1, 3, 0); // idle: no load
    tbl[14] = mk(0, D1, 0, 0, 1, 0,   D4,    0, 0, 0, 0, 3, 0); // idle: no stall
    tbl[15] = mk(1, 10'h0, 0, 0, 0, 0, D4,   0, 0, 0, 0, 3, 0);
    tbl[16] = mk(1, D3, 1, 1, 1, 0,   D4,    0, 0, 1, 0, 3, 0); // fetch, then no Clr
    tbl[17] = mk(1, 10'h0, 0, 0, 0, 0, D3,   1, 0, 0, 0, 3, 0);
    tbl[18] = mk(1, 10'h0, 0, 0, 0, 0, D3,   2, 0, 0, 0, 3, 0);
    tbl[19] = mk(1, 10'h0, 0, 0, 0, 0, D3,   3, 0, 0, 0, 3, 0);
    tbl[20] = mk(1, 10'h0, 0, 0, 0, 0, D3,   0, 0, 0, 0, 3, 1); // wrapped, seq_err
    tbl[21] = mk(1, 10'h0, 0, 0, 0, 1, D3,   1, 0, 0, 0, 3, 1);
    tbl[22] = mk(1, 10'h0, 0, 0, 0, 0, D3,   0, 0, 0, 1, 4, 1); // seq_err sticky
    tbl[23] = mk(1, 10'h0, 0, 0, 0, 1, D3,   1, 0, 0, 0, 4, 1);

    rst_n = 1'b0;
    drive(0, 10'h0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset IR", IR, 10'h0);
    chk("reset timestep", timestep, 2'd0);
    chk("reset instr_count", instr_count, 16'd0);
    chk("reset instr_done", instr_done, 1'b0);
    chk("reset seq_err", seq_err, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      @(posedge clk);
      #1;
      drive(tbl[i].run, tbl[i].data, tbl[i].valid, tbl[i].irin, tbl[i].ext, tbl[i].clr);
      @(negedge clk);
      chk($sformatf("row%0d IR", i), IR, tbl[i].ir);
      chk($sformatf("row%0d timestep", i), timestep, tbl[i].ts);
      chk($sformatf("row%0d stall", i), stall, tbl[i].stall);
      chk($sformatf("row%0d data_ready", i), bus.data_ready, tbl[i].ready);
      chk($sformatf("row%0d instr_done", i), instr_done, tbl[i].done);
      chk($sformatf("row%0d instr_count", i), instr_count, tbl[i].cnt);
      chk($sformatf("row%0d seq_err", i), seq_err, tbl[i].err);
    end

    // run drops at ts0 while the fetch is stalled: must stay running
    @(posedge clk); #1;
    drive(0, D1, 0, 1, 1, 0);
    @(negedge clk);
    chk("halt-stall stall0", stall, 1'b1);
    chk("halt-stall ts0", timestep, 2'd0);
    chk("halt-stall done", instr_done, 1'b1);
    chk("halt-stall cnt", instr_count, 16'd5);
    @(posedge clk); #1;
    @(negedge clk);
    chk("halt-stall stall1", stall, 1'b1);
    chk("halt-stall ts1", timestep, 2'd0);
    chk("halt-stall IR held", IR, D3);
    @(posedge clk); #1;
    bus.data_valid = 1'b1;
    @(negedge clk);
    chk("halt-stall released", stall, 1'b0);
    chk("halt-stall ready", bus.data_ready, 1'b1);
    @(posedge clk); #1;
    drive(0, 10'h0, 0, 0, 0, 1);
    @(negedge clk);
    chk("halt-stall IR loaded", IR, D1);
    chk("halt-stall ts advanced", timestep, 2'd1);
    @(posedge clk); #1;
    drive(0, D2, 1, 0, 1, 0);
    @(negedge clk);
    chk("halt-stall idle ready", bus.data_ready, 1'b0);
    chk("halt-stall idle ts", timestep, 2'd0);
    chk("halt-stall done2", instr_done, 1'b1);
    chk("halt-stall cnt2", instr_count, 16'd6);

    // asynchronous reset at ts2 with a fetch pending
    @(posedge clk); #1;
    drive(1, 10'h0, 0, 0, 0, 0);
    @(posedge clk); #1;
    drive(1, D2, 1, 1, 1, 0);
    @(posedge clk); #1;
    drive(1, 10'h0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("pre-reset ts", timestep, 2'd2);
    chk("pre-reset IR", IR, D2);
    drive(1, D4, 1, 1, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset IR", IR, 10'h0);
    chk("async reset ts", timestep, 2'd0);
    chk("async reset cnt", instr_count, 16'd0);
    chk("async reset idle ready", bus.data_ready, 1'b0);
    @(posedge clk); #1;
    chk("held reset IR", IR, 10'h0);
    chk("held reset ts", timestep, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post-reset ready", bus.data_ready, 1'b1);
    chk("post-reset IR", IR, 10'h0);
    @(posedge clk); #1;
    chk("post-reset fetch IR", IR, D4);
    chk("post-reset fetch ts", timestep, 2'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
